alu_ctrl_exec: RTL and testbench
================================

Name: alu_ctrl_exec

Overview:
Parametrised successor to the lab ALU control decoder. Merges the alu_op/funct decode with a registered execute stage. Adds a multi-cycle shift-add multiplier (mult/multu) with HI/LO registers, plus mfhi/mflo reads, behind a start/ready/valid handshake. Sits in the EX stage of the multi-cycle MIPS datapath and is driven by the main control unit and the register file read ports.

Parameters:
DATA_WIDTH, 32, operand/result width in bits (>= 4, even)
CNT_WIDTH, 6, multiplier iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; accepted on a rising edge when start & ready
ready  out  1  high when a new request can be accepted
alu_op  in  2  from main control: 00 add, 01 sub, 10 use funct, 11 invalid
instruction_5_0  in  6  funct field
a  in  DATA_WIDTH  operand rs
b  in  DATA_WIDTH  operand rt
alu_out  out  4  registered ALU control code of the last accepted op
result  out  DATA_WIDTH  registered result
zero  out  1  (result == 0); valid while valid is high
valid  out  1  one-cycle pulse when result is ready
err  out  1  one-cycle pulse with valid for an undefined alu_op/funct
hi  out  DATA_WIDTH  HI register
lo  out  DATA_WIDTH  LO register

Behaviour:
- Reset (async, immediate): state=IDLE, ready=1. valid, err, zero=0. result, hi, lo=0. alu_out=4'b0000. Counter cleared. Reset asserted mid-multiply aborts the operation; HI/LO are not written.
- Decode applied to inputs sampled at the acceptance edge:
  - alu_op 00: alu_out=0010, add.
  - alu_op 01: alu_out=0110, sub.
  - alu_op 10 with funct:
    - 100000 add: 0010
    - 100010 sub: 0110
    - 100100 and: 0000
    - 100101 or: 0001
    - 100111 nor: 1100
    - 101010 slt: 0111
    - 011000 mult: 1000
    - 011001 multu: 1001
    - 010000 mfhi: 1010
    - 010010 mflo: 1011
  - Anything else, including alu_op 11: alu_out=1111, result=0, err=1.
- Arithmetic: add/sub wrap modulo 2^DATA_WIDTH with no overflow trap. slt is a signed compare; result = 1 or 0, zero-extended. mfhi/mflo return the current hi/lo.
- Single-cycle ops (everything except mult/multu): accepted at edge E. result, alu_out, zero, err update at E; valid is high for the cycle after E. ready stays 1, so back-to-back issue every cycle is legal.
- State machine: IDLE -> MUL on accepted mult/multu; MUL -> IDLE after the last iteration.
  - In IDLE, ready=1. In MUL, ready=0 and start is ignored; nothing is queued.
  - At acceptance: latch operands. For mult, latch |a| and |b| and record sign = a[MSB]^b[MSB]. |-2^(W-1)| is taken as unsigned 2^(W-1).
  - One add-shift iteration per cycle; DATA_WIDTH iterations at edges E+1..E+DATA_WIDTH.
  - At edge E+DATA_WIDTH: {hi,lo} = 2W-bit product, negated in two's complement if mult and sign=1. result=lo, zero=(lo==0), valid high for the following cycle, state=IDLE, ready=1.
  - Earliest next acceptance is edge E+DATA_WIDTH+1.
- hi/lo change only on multiply completion or reset.

Test Plan:
- Reset then alu_op=00, a=5, b=3, start one cycle -> next cycle valid=1, result=8, alu_out=0010, zero=0, ready stays 1.
- Back-to-back with alu_op=10: sub 5-5 -> result 0, zero=1, alu_out 0110. slt a=FFFFFFFF, b=1 -> result 1, alu_out 0111. nor 0,0 -> FFFFFFFF, alu_out 1100. One result per cycle.
- mult a=FFFFFFFD (-3), b=7 -> ready=0 for 32 cycles; start pulsed mid-way is ignored; then hi=FFFFFFFF, lo=FFFFFFEB, result=FFFFFFEB, valid one cycle. Follow with mfhi -> FFFFFFFF.
- multu a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE. mult a=80000000, b=80000000 -> hi=40000000, lo=00000000, zero=1.
- alu_op=11, and alu_op=10 with funct=111111 -> alu_out=1111, result=0, err=1 with valid; hi/lo unchanged.
- Assert rst asynchronously (between clock edges) 10 cycles into a mult -> outputs at reset values immediately, ready=1, hi=lo=0. After release, add 1+1 -> 2.

Source files
------------

// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU: alu_op/funct decode plus a registered execute stage, with a
// multi-cycle shift-add multiplier (mult/multu) feeding HI/LO and mfhi/mflo reads.
module alu_ctrl_exec #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic [1:0]            alu_op,
    input  logic [5:0]            instruction_5_0,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [3:0]            alu_out,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int unsigned W = DATA_WIDTH;

    localparam logic [3:0] CodeAnd   = 4'b0000;
    localparam logic [3:0] CodeOr    = 4'b0001;
    localparam logic [3:0] CodeAdd   = 4'b0010;
    localparam logic [3:0] CodeSub   = 4'b0110;
    localparam logic [3:0] CodeSlt   = 4'b0111;
    localparam logic [3:0] CodeMult  = 4'b1000;
    localparam logic [3:0] CodeMultu = 4'b1001;
    localparam logic [3:0] CodeMfhi  = 4'b1010;
    localparam logic [3:0] CodeMflo  = 4'b1011;
    localparam logic [3:0] CodeNor   = 4'b1100;
    localparam logic [3:0] CodeErr   = 4'b1111;

    typedef enum logic {StIdle, StMul} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             alu_out_q, alu_out_d;
    logic [W-1:0]           result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [W-1:0]           hi_q, hi_d;
    logic [W-1:0]           lo_q, lo_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [W-1:0]           mcand_q, mcand_d;
    logic [2*W-1:0]         prod_q, prod_d;
    logic                   neg_q, neg_d;

    logic [3:0]             dec_code;
    logic                   dec_err;
    logic [W-1:0]           op_result;
    logic [W-1:0]           abs_a, abs_b;
    logic                   is_mult, is_multu;
    logic [W:0]             add_sum;
    logic [2*W-1:0]         prod_step, prod_final;

    // Decode alu_op/funct into the 4-bit ALU control code.
    always_comb begin
        dec_code = CodeErr;
        dec_err  = 1'b1;
        case (alu_op)
            2'b00: begin dec_code = CodeAdd; dec_err = 1'b0; end
            2'b01: begin dec_code = CodeSub; dec_err = 1'b0; end
            2'b10: begin
                dec_err = 1'b0;
                case (instruction_5_0)
                    6'b100000: dec_code = CodeAdd;
                    6'b100010: dec_code = CodeSub;
                    6'b100100: dec_code = CodeAnd;
                    6'b100101: dec_code = CodeOr;
                    6'b100111: dec_code = CodeNor;
                    6'b101010: dec_code = CodeSlt;
                    6'b011000: dec_code = CodeMult;
                    6'b011001: dec_code = CodeMultu;
                    6'b010000: dec_code = CodeMfhi;
                    6'b010010: dec_code = CodeMflo;
                    default:   dec_err  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // Single-cycle datapath result for the decoded op; undefined ops give 0.
    always_comb begin
        op_result = '0;
        case (dec_code)
            CodeAdd:  op_result = a + b;
            CodeSub:  op_result = a - b;
            CodeAnd:  op_result = a & b;
            CodeOr:   op_result = a | b;
            CodeNor:  op_result = ~(a | b);
            CodeSlt:  op_result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            CodeMfhi: op_result = hi_q;
            CodeMflo: op_result = lo_q;
            default:  op_result = '0;
        endcase
    end

    // Operand magnitudes and one shift-add step of the multiplier.
    always_comb begin
        is_mult    = (dec_code == CodeMult);
        is_multu   = (dec_code == CodeMultu);
        // Negating the most negative value wraps to 2^(W-1), which is the
        // correct unsigned magnitude.
        abs_a      = (is_mult && a[W-1]) ? -a : a;
        abs_b      = (is_mult && b[W-1]) ? -b : b;
        add_sum    = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? mcand_q : {W{1'b0}})};
        prod_step  = {add_sum, prod_q[W-1:1]};
        prod_final = neg_q ? -prod_step : prod_step;
    end

    // Next-state: accept in idle, iterate in multiply, pulse valid/err.
    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        result_d  = result_q;
        zero_d    = zero_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        neg_d     = neg_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    alu_out_d = dec_code;
                    if (is_mult || is_multu) begin
                        state_d = StMul;
                        mcand_d = abs_a;
                        prod_d  = {{W{1'b0}}, abs_b};
                        neg_d   = is_mult & (a[W-1] ^ b[W-1]);
                        cnt_d   = '0;
                    end else begin
                        result_d = op_result;
                        zero_d   = (op_result == '0);
                        err_d    = dec_err;
                        valid_d  = 1'b1;
                    end
                end
            end
            StMul: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(W - 1)) begin
                    hi_d     = prod_final[2*W-1:W];
                    lo_d     = prod_final[W-1:0];
                    result_d = prod_final[W-1:0];
                    zero_d   = (prod_final[W-1:0] == '0);
                    valid_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            alu_out_q <= 4'b0000;
            result_q  <= '0;
            zero_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            neg_q     <= neg_d;
        end
    end

    assign ready   = (state_q == StIdle);
    assign alu_out = alu_out_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed-vector bench for alu_ctrl_exec (DATA_WIDTH = 32).
module tb_alu_ctrl_exec;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ready;
    logic [1:0]   alu_op;
    logic [5:0]   instruction_5_0;
    logic [W-1:0] a, b;
    logic [3:0]   alu_out;
    logic [W-1:0] result;
    logic         zero, valid, err;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    alu_ctrl_exec #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .alu_op(alu_op),
        .instruction_5_0(instruction_5_0), .a(a), .b(b), .alu_out(alu_out),
        .result(result), .zero(zero), .valid(valid), .err(err), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Present one request for exactly one rising edge; returns 1ns after it.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] aa, input logic [W-1:0] bb);
        alu_op = op; instruction_5_0 = fn; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; alu_op = 2'b00; instruction_5_0 = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (alu_out !== 4'b0000) begin errors++; $display("FAIL reset_alu_out got %b exp 0000", alu_out); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h %h exp 0 0", hi, lo); end
    endtask

    task automatic test_add;
        issue(2'b00, 6'b000000, 32'd5, 32'd3);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", valid); end
        checks++; if (result !== 32'd8) begin errors++; $display("FAIL add_result got %h exp 8", result); end
        checks++; if (alu_out !== 4'b0010) begin errors++; $display("FAIL add_alu_out got %b exp 0010", alu_out); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", zero); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b exp 1", ready); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL add_valid_pulse got %b exp 0", valid); end
        issue(2'b01, 6'b111111, 32'd10, 32'd4);
        checks++; if (result !== 32'd6 || alu_out !== 4'b0110) begin
            errors++; $display("FAIL op01_sub got %h/%b exp 6/0110", result, alu_out); end
    endtask

    task automatic test_back_to_back;
        issue(2'b10, 6'b100010, 32'd5, 32'd5);
        checks++; if (result !== 32'h0 || zero !== 1'b1 || alu_out !== 4'b0110 || valid !== 1'b1) begin
            errors++; $display("FAIL b2b_sub got %h z%b %b v%b exp 0 z1 0110 v1", result, zero, alu_out, valid); end
        issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        checks++; if (result !== 32'd1 || alu_out !== 4'b0111 || valid !== 1'b1 || zero !== 1'b0) begin
            errors++; $display("FAIL b2b_slt got %h %b v%b z%b exp 1 0111 v1 z0", result, alu_out, valid, zero); end
        issue(2'b10, 6'b100111, 32'h0, 32'h0);
        checks++; if (result !== 32'hFFFF_FFFF || alu_out !== 4'b1100 || valid !== 1'b1) begin
            errors++; $display("FAIL b2b_nor got %h %b v%b exp ffffffff 1100 v1", result, alu_out, valid); end
        issue(2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
        checks++; if (result !== 32'h00F0_1200 || alu_out !== 4'b0000) begin
            errors++; $display("FAIL b2b_and got %h %b exp 00f01200 0000", result, alu_out); end
        issue(2'b10, 6'b100101, 32'hF000_0001, 32'h0000_0F00);
        checks++; if (result !== 32'hF000_0F01 || alu_out !== 4'b0001) begin
            errors++; $display("FAIL b2b_or got %h %b exp f0000f01 0001", result, alu_out); end
        issue(2'b10, 6'b101010, 32'd3, 32'hFFFF_FFFE);
        checks++; if (result !== 32'd0 || zero !== 1'b1) begin
            errors++; $display("FAIL b2b_slt_false got %h z%b exp 0 z1", result, zero); end
        issue(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd2);
        checks++; if (result !== 32'd1 || alu_out !== 4'b0010) begin
            errors++; $display("FAIL b2b_add_wrap got %h %b exp 1 0010", result, alu_out); end
    endtask

    // Runs one multiply with a stray start mid-way and checks latency and HI/LO.
    task automatic run_mult(input string name, input logic [5:0] fn, input logic [W-1:0] aa,
                            input logic [W-1:0] bb, input logic [W-1:0] exp_hi,
                            input logic [W-1:0] exp_lo, input logic [3:0] exp_code);
        int  n = 0;
        bit  got = 0;
        bit  ready_ok = 1;
        issue(2'b10, fn, aa, bb);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL %s_busy got %b exp 0", name, ready); end
        for (int i = 1; i <= 40 && !got; i++) begin
            if (i == 10) begin alu_op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1; end
            @(posedge clk); #1;
            start = 1'b0;
            if (valid === 1'b1) begin got = 1; n = i; end
            else if (ready !== 1'b0) ready_ok = 0;
        end
        checks++; if (!got || n != 32) begin errors++; $display("FAIL %s_latency got %0d exp 32", name, n); end
        checks++; if (!ready_ok) begin errors++; $display("FAIL %s_ready_low got early ready exp 0", name); end
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi got %h exp %h", name, hi, exp_hi); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s_lo got %h exp %h", name, lo, exp_lo); end
        checks++; if (result !== exp_lo) begin errors++; $display("FAIL %s_result got %h exp %h", name, result, exp_lo); end
        checks++; if (zero !== (exp_lo == '0)) begin errors++; $display("FAIL %s_zero got %b", name, zero); end
        checks++; if (alu_out !== exp_code) begin errors++; $display("FAIL %s_alu_out got %b exp %b", name, alu_out, exp_code); end
        checks++; if (ready !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL %s_done got ready %b err %b exp 1 0", name, ready, err); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s_valid_pulse got %b exp 0", name, valid); end
    endtask

    task automatic test_mult;
        run_mult("mult_neg", 6'b011000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4'b1000);
        issue(2'b10, 6'b010000, 32'h1234, 32'h5678);
        checks++; if (result !== 32'hFFFF_FFFF || alu_out !== 4'b1010) begin
            errors++; $display("FAIL mfhi got %h %b exp ffffffff 1010", result, alu_out); end
        issue(2'b10, 6'b010010, 32'h0, 32'h0);
        checks++; if (result !== 32'hFFFF_FFEB || alu_out !== 4'b1011) begin
            errors++; $display("FAIL mflo got %h %b exp ffffffeb 1011", result, alu_out); end
        run_mult("multu", 6'b011001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1001);
        run_mult("mult_min", 6'b011000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 4'b1000);
    endtask

    task automatic test_err;
        issue(2'b00, 6'b000000, 32'd5, 32'd3);
        issue(2'b11, 6'b100000, 32'd5, 32'd3);
        checks++; if (alu_out !== 4'b1111 || result !== 32'h0 || err !== 1'b1 || valid !== 1'b1) begin
            errors++; $display("FAIL err_op11 got %b %h e%b v%b exp 1111 0 e1 v1", alu_out, result, err, valid); end
        issue(2'b00, 6'b000000, 32'd7, 32'd0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
        issue(2'b10, 6'b111111, 32'd7, 32'd1);
        checks++; if (alu_out !== 4'b1111 || result !== 32'h0 || err !== 1'b1 || valid !== 1'b1) begin
            errors++; $display("FAIL err_funct got %b %h e%b v%b exp 1111 0 e1 v1", alu_out, result, err, valid); end
        checks++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            errors++; $display("FAIL err_hilo got %h %h exp 40000000 0", hi, lo); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", err); end
    endtask

    task automatic test_async_reset;
        issue(2'b10, 6'b011001, 32'd100, 32'd3);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", ready); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL arst_hilo got %h %h exp 0 0", hi, lo); end
        checks++; if (alu_out !== 4'b0000 || result !== 32'h0 || valid !== 1'b0) begin
            errors++; $display("FAIL arst_outputs got %b %h v%b exp 0000 0 v0", alu_out, result, valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        issue(2'b00, 6'b000000, 32'd1, 32'd1);
        checks++; if (result !== 32'd2 || valid !== 1'b1) begin
            errors++; $display("FAIL arst_add got %h v%b exp 2 v1", result, valid); end
        repeat (40) @(posedge clk); #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL arst_abort got %h %h exp 0 0", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mult();
        test_err();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
